rle_encoder: RTL and testbench
==============================

RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 Parameter COEF_W, default 19: signed coefficient width, matching the DCT stage output.
REQ-002 Parameter BLOCK_LEN, default 8: coefficients per block.
REQ-003 Parameter QSHIFT, default 4: quantiser right-shift amount.
REQ-004 Parameter RUN_W, default 3: run-length field width, equal to clog2(BLOCK_LEN).
REQ-005 clk  in  1: single clock; all state changes on the rising edge.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 in_valid  in  1: in_coef is valid.
REQ-008 in_ready  out  1: block accepts in_coef; transfer occurs when in_valid && in_ready on a rising edge.
REQ-009 in_coef  in  COEF_W: signed DCT coefficient, in block order, index 0 first.
REQ-010 out_valid  out  1: symbol is valid.
REQ-011 out_ready  in  1: downstream accepts the symbol; transfer occurs when out_valid && out_ready on a rising edge.
REQ-012 out_run  out  RUN_W: count of zero-quantised coefficients preceding this symbol in the block.
REQ-013 out_level  out  COEF_W-QSHIFT: signed quantised level.
REQ-014 out_eob  out  1: symbol is the last of its block.

Function
REQ-015 Quantisation SHALL round toward zero: q = (c + (c<0 ? 2^QSHIFT-1 : 0)) >>> QSHIFT; for example -15 gives 0, -16 gives -1, 160 gives 10.
REQ-016 FSM states SHALL be S_START (position 0 expected, run 0) and S_MID (positions 1..BLOCK_LEN-1); an accepted coefficient at position 0 moves S_START to S_MID, and an accepted last coefficient returns to S_START.
REQ-017 The position counter SHALL advance only on an input transfer and wrap from BLOCK_LEN-1 to 0.
REQ-018 An accepted non-last coefficient with q==0 SHALL increment the run counter and emit no symbol.
REQ-019 An accepted coefficient with q!=0 SHALL emit (run, q, eob = last position) and clear the run counter.
REQ-020 An accepted last coefficient with q==0 SHALL emit an EOB token (run, 0, 1) and clear the run counter.
REQ-021 A symbol SHALL be registered: out_valid rises on the cycle after the accepting edge, a latency of 1 cycle.
REQ-022 in_ready SHALL equal !out_valid || out_ready (combinational), so there is no overflow and no symbol loss.
REQ-023 While out_valid && !out_ready, out_run, out_level and out_eob SHALL hold stable.
REQ-024 A simultaneous output transfer and new-symbol load SHALL replace the symbol in the same edge with no bubble.
REQ-025 An output transfer with no new symbol SHALL clear out_valid.
REQ-026 Run SHALL never exceed BLOCK_LEN-1, so RUN_W cannot overflow.

Reset
REQ-027 rst SHALL asynchronously clear the state to S_START, the position and run counters to 0, out_valid to 0, out_run to 0, out_level to 0 and out_eob to 0.
REQ-028 Reset mid-block SHALL discard the partial block; the first coefficient accepted after rst deasserts is position 0.
REQ-029 in_ready SHALL be 1 while out_valid is 0, including during reset.

Configuration
REQ-030 Macro RLE_STATS_EN defined SHALL add output sym_count (16 bits, unsigned), counting output transfers, saturating at 0xFFFF, and cleared by rst.
REQ-031 Macro RLE_STATS_EN undefined SHALL mean the port and counter are absent, with otherwise identical behaviour.

Verification
REQ-032 Block [160,0,0,32,0,0,0,0] with out_ready=1 -> symbols (0,10,0), (2,2,0), (3,0,1).
REQ-033 Block [0,15,-15,7,0,-3,1,0] -> single symbol (7,0,1).
REQ-034 Block [0,0,0,0,0,0,0,-48] -> single symbol (7,-3,1); the next block starts at position 0.
REQ-035 out_ready=0 for 5 cycles while a symbol is pending -> in_ready=0 for those cycles, outputs stable, no symbol lost or duplicated after release.
REQ-036 rst pulse after 3 coefficients of a block, then block [16,0,0,0,0,0,0,16] -> outputs 0 during reset, then (0,1,0), (6,1,1).
REQ-037 With RLE_STATS_EN defined, after the REQ-032 stimulus -> sym_count=3; after a further 65535 output transfers -> sym_count stays 0xFFFF.

Source files
------------

// File: rtl/rle_encoder.sv
// rle_encoder: quantises a stream of signed DCT coefficients and emits (run, level, eob) symbols.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_coef is valid
//   in_ready   coefficient accepted on the edge when in_valid && in_ready
//   in_coef    signed coefficient, block order, index 0 first
//   out_valid  symbol is valid
//   out_ready  downstream accepts the symbol when out_valid && out_ready
//   out_run    zero-quantised coefficients preceding this symbol in the block
//   out_level  signed quantised level
//   out_eob    symbol is the last of its block
//   sym_count  (RLE_STATS_EN only) saturating 16-bit count of output transfers
//
// Optional feature: define RLE_STATS_EN to add the sym_count output.
module rle_encoder #(
    parameter int COEF_W    = 19,
    parameter int BLOCK_LEN = 8,
    parameter int QSHIFT    = 4,
    parameter int RUN_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COEF_W-1:0]        in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RUN_W-1:0]         out_run,
    output logic [COEF_W-QSHIFT-1:0] out_level,
`ifdef RLE_STATS_EN
    output logic                     out_eob,
    output logic [15:0]              sym_count
`else
    output logic                     out_eob
`endif
);

    typedef enum logic {S_START, S_MID} state_t;

    localparam logic [RUN_W-1:0]         LAST_POS = RUN_W'(BLOCK_LEN - 1);
    localparam logic signed [COEF_W-1:0] BIAS     = COEF_W'((1 << QSHIFT) - 1);

    state_t                    state_q, state_d;
    logic [RUN_W-1:0]          pos_q, pos_d;
    logic [RUN_W-1:0]          run_q, run_d;
    logic                      out_valid_q, out_valid_d;
    logic [RUN_W-1:0]          out_run_q, out_run_d;
    logic [COEF_W-QSHIFT-1:0]  out_level_q, out_level_d;
    logic                      out_eob_q, out_eob_d;
    logic signed [COEF_W-1:0]  sum;
    logic signed [COEF_W-1:0]  q_full;
    logic                      last, xfer_in, emit;

    always_comb begin
        // Negative values get a bias of 2^QSHIFT-1 so the arithmetic shift truncates toward zero.
        sum         = in_coef[COEF_W-1] ? $signed(in_coef) + BIAS : $signed(in_coef);
        q_full      = sum >>> QSHIFT;
        last        = pos_q == LAST_POS;
        in_ready    = !out_valid_q || out_ready;
        xfer_in     = in_valid && in_ready;
        // The output register is free whenever a coefficient is accepted, so a symbol never waits.
        emit        = xfer_in && (q_full != '0 || last);
        state_d     = state_q;
        if (xfer_in)
            state_d = last ? S_START : S_MID;
        pos_d       = xfer_in ? (last ? '0 : pos_q + 1'b1) : pos_q;
        run_d       = xfer_in ? (emit ? '0 : run_q + 1'b1) : run_q;
        out_valid_d = emit || (out_valid_q && !out_ready);
        out_run_d   = emit ? run_q : out_run_q;
        out_level_d = emit ? q_full[COEF_W-QSHIFT-1:0] : out_level_q;
        out_eob_d   = emit ? last : out_eob_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_START;
            pos_q       <= '0;
            run_q       <= '0;
            out_valid_q <= 1'b0;
            out_run_q   <= '0;
            out_level_q <= '0;
            out_eob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            out_run_q   <= out_run_d;
            out_level_q <= out_level_d;
            out_eob_q   <= out_eob_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_run   = out_run_q;
    assign out_level = out_level_q;
    assign out_eob   = out_eob_q;

`ifdef RLE_STATS_EN
    logic [15:0] sym_count_q, sym_count_d;

    always_comb begin
        sym_count_d = (out_valid_q && out_ready && sym_count_q != 16'hFFFF) ? sym_count_q + 16'd1 : sym_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sym_count_q <= '0;
        else
            sym_count_q <= sym_count_d;
    end

    assign sym_count = sym_count_q;
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// tb_rle_encoder: randomized and directed check of rle_encoder against a queue-based reference model.
module tb_rle_encoder;

    localparam int COEF_W    = 19;
    localparam int BLOCK_LEN = 8;
    localparam int QSHIFT    = 4;
    localparam int RUN_W     = 3;
    localparam int LVL_W     = COEF_W - QSHIFT;

    typedef struct {
        int run;
        int lvl;
        int eob;
    } sym_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [RUN_W-1:0]  out_run;
    logic [LVL_W-1:0]  out_level;
    logic              out_eob;
`ifdef RLE_STATS_EN
    logic [15:0]       sym_count;
`endif

    int   n_chk;
    int   n_pass;
    sym_t exp_q[$];
    int   m_pos;
    int   m_run;
    int   ref_cnt;
    bit   exp_v;
    bit   hold;
    int   p_run;
    int   p_lvl;
    int   p_eob;
    bit   done;

    rle_encoder #(
        .COEF_W(COEF_W), .BLOCK_LEN(BLOCK_LEN), .QSHIFT(QSHIFT), .RUN_W(RUN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_coef(in_coef),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_run(out_run),
        .out_level(out_level),
`ifdef RLE_STATS_EN
        .out_eob(out_eob),
        .sym_count(sym_count)
`else
        .out_eob(out_eob)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: truncating integer division is exactly round-toward-zero quantisation.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_run", int'(out_run), 0);
            chk("rst_out_level", int'($signed(out_level)), 0);
            chk("rst_out_eob", int'(out_eob), 0);
            exp_q.delete();
            m_pos   = 0;
            m_run   = 0;
            ref_cnt = 0;
            exp_v   = 0;
            hold    = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_run", int'(out_run), p_run);
                chk("hold_level", int'($signed(out_level)), p_lvl);
                chk("hold_eob", int'(out_eob), p_eob);
            end
            if (exp_v)
                chk("latency", int'(out_valid), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_symbol", 1, 0);
                end else begin
                    sym_t s;
                    s = exp_q.pop_front();
                    chk("sym_run", int'(out_run), s.run);
                    chk("sym_level", int'($signed(out_level)), s.lvl);
                    chk("sym_eob", int'(out_eob), s.eob);
                end
                if (ref_cnt < 65535)
                    ref_cnt++;
            end
            hold  = out_valid && !out_ready;
            p_run = int'(out_run);
            p_lvl = int'($signed(out_level));
            p_eob = int'(out_eob);
            exp_v = 0;
            if (in_valid && in_ready) begin
                int c;
                int q;
                bit lst;
                c   = int'($signed(in_coef));
                q   = c / (1 << QSHIFT);
                lst = (m_pos == BLOCK_LEN - 1);
                if (q != 0 || lst) begin
                    exp_q.push_back('{run: m_run, lvl: q, eob: int'(lst)});
                    exp_v = 1;
                    m_run = 0;
                end else begin
                    m_run++;
                end
                m_pos = lst ? 0 : m_pos + 1;
            end
        end
    end

    task automatic send(input int c);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        in_coef  = COEF_W'(c);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc)
            chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_block(input int b[BLOCK_LEN]);
        for (int i = 0; i < BLOCK_LEN; i++)
            send(b[i]);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_coef();
        case ($urandom_range(0, 3))
            0: return 0;
            1: return int'($urandom_range(0, 63)) - 32;
            2: return (int'($urandom_range(0, 20)) - 10) * 16;
            default: return int'($signed(COEF_W'($urandom)));
        endcase
    endfunction

    initial begin
        int b[BLOCK_LEN];
        n_chk     = 0;
        n_pass    = 0;
        done      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_coef   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        b = '{160, 0, 0, 32, 0, 0, 0, 0};
        send_block(b);
        drain();
`ifdef RLE_STATS_EN
        chk("sym_count_3", int'(sym_count), 3);
`endif
        b = '{0, 15, -15, 7, 0, -3, 1, 0};
        send_block(b);
        b = '{0, 0, 0, 0, 0, 0, 0, -48};
        send_block(b);
        b = '{-16, 0, 0, 0, 0, 0, 0, 0};
        send_block(b);
        drain();

        out_ready = 1'b0;
        send(160);
        in_valid = 1'b1;
        in_coef  = COEF_W'(32);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32);
        for (int i = 0; i < BLOCK_LEN - 2; i++)
            send(0);
        drain();

        send(5);
        send(0);
        send(100);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        b = '{16, 0, 0, 0, 0, 0, 0, 16};
        send_block(b);
        drain();

        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rand_coef());
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

`ifdef RLE_STATS_EN
        chk("sym_count_model", int'(sym_count), ref_cnt);
        in_valid = 1'b1;
        in_coef  = COEF_W'(160);
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("sym_count_sat", int'(sym_count), 65535);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
